// File: rtl/disp_bcd_pkg.sv
// Shared definitions for the sequential BCD segment display path.
// Holds the controller state encoding, the segment constants, and the 0-9
// glyph table used to encode each decimal digit.
// Segment bytes are active low: bit7 = decimal point, bits 6..0 = g..a.
package disp_bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CONV  = 2'd1,
      SHIFT = 2'd2,
      LATCH = 2'd3
   } dispState_t;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   // Glyph table for decimal digits, g..a active low. Codes 10-15 cannot come
   // out of the double-dabble register, so they fall back to an unlit digit.
   function automatic logic [6:0] seg7Glyph(input logic [3:0] nibble);
      logic [6:0] glyph;
      case (nibble)
         4'd0:    glyph = 7'h40;
         4'd1:    glyph = 7'h79;
         4'd2:    glyph = 7'h24;
         4'd3:    glyph = 7'h30;
         4'd4:    glyph = 7'h19;
         4'd5:    glyph = 7'h12;
         4'd6:    glyph = 7'h02;
         4'd7:    glyph = 7'h78;
         4'd8:    glyph = 7'h00;
         4'd9:    glyph = 7'h10;
         default: glyph = SEG_BLANK[6:0];
      endcase
      return glyph;
   endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational encoder from a single BCD nibble plus its decimal-point flag
// to the active-low 7-segment byte placed on the display shift chain.
// Ports:
//   nibble_i  [3:0]  BCD digit value 0-9
//   dp_i             decimal point enable (1 = point lit)
//   seg_o     [7:0]  {dp, g..a}, active low
module bcd_to_seg7
   import disp_bcd_pkg::*;
(
   input  logic [3:0] nibble_i,
   input  logic       dp_i,
   output logic [7:0] seg_o
);

   // The point segment is active low like the others, so an enabled point clears bit7.
   assign seg_o = {~dp_i, seg7Glyph(nibble_i)};

endmodule

// File: rtl/disp_bcd_seq.sv
// Sequential binary-to-display path for the shift-register LED board.
// A value latched on an accepted load is converted to BCD by double dabble,
// one input bit per clock, then every digit is encoded to 7-segment form and
// the whole frame is shifted out MSB first on the 4-wire segment bus, ending
// with a one-cycle output-latch strobe.
// Optional build macro: DISP_BCD_LZ_BLANK_EN blanks leading-zero digits.
// Ports:
//   clk, rst_n           system clock, asynchronous active-low reset
//   load                 start request, accepted only while busy is low
//   bin   [BIN_BITS-1:0] unsigned value captured on accepted load
//   point [DIGITS-1:0]   per-digit decimal point enables captured on load
//   busy                 conversion/shift in progress
//   done                 one-cycle pulse as the frame is latched
//   ovf                  value did not fit in DIGITS decimal digits
//   seg_clk, seg_do      serial shift clock and data
//   seg_pen              output-latch enable, low while shifting
//   seg_clr              shift-register clear, active low
module disp_bcd_seq
   import disp_bcd_pkg::*;
#(
   parameter int BIN_BITS = 32,
   parameter int DIGITS   = 8,
   parameter int CLK_DIV  = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load,
   input  logic [BIN_BITS-1:0] bin,
   input  logic [DIGITS-1:0]   point,
   output logic                busy,
   output logic                done,
   output logic                ovf,
   output logic                seg_clk,
   output logic                seg_do,
   output logic                seg_pen,
   output logic                seg_clr
);

   localparam int BW = DIGITS * 4;
   localparam int FW = DIGITS * 8;
   localparam int CW = $clog2(BIN_BITS);
   localparam int IW = $clog2(FW);
   localparam int DW = $clog2(2 * CLK_DIV);

   localparam logic [CW-1:0] CONV_LAST = CW'(BIN_BITS - 1);
   localparam logic [IW-1:0] BIT_LAST  = IW'(FW - 1);
   localparam logic [DW-1:0] DIV_HALF  = DW'(CLK_DIV);
   localparam logic [DW-1:0] DIV_LAST  = DW'(2 * CLK_DIV - 1);

   dispState_t          state_q, state_d;
   logic [CW-1:0]       convCnt_q, convCnt_d;
   logic [IW-1:0]       bitIdx_q, bitIdx_d;
   logic [DW-1:0]       divCnt_q, divCnt_d;
   logic [BW-1:0]       bcd_q, bcd_d;
   logic [BIN_BITS-1:0] binSh_q, binSh_d;
   logic [DIGITS-1:0]   point_q, point_d;
   logic                ovf_q, ovf_d;
   logic                clr_q;

   logic [BW-1:0]       bcdAdj;
   logic [FW-1:0]       digitSeg;
   logic [FW-1:0]       frame;
   logic                accept;

   // Add-3 correction: any nibble of 5 or more would exceed 9 after the
   // doubling shift, so it is pre-biased to carry into the next digit.
   always_comb begin
      bcdAdj = bcd_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_q[i*4 +: 4] >= 4'd5) begin
            bcdAdj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
         end
      end
   end

   // One encoder per digit; digit 0 is the least significant and sits in the low byte.
   for (genvar g = 0; g < DIGITS; g++) begin : gen_seg
      bcd_to_seg7 u_seg (
         .nibble_i (bcd_q[g*4 +: 4]),
         .dp_i     (point_q[g]),
         .seg_o    (digitSeg[g*8 +: 8])
      );
   end

   // Frame assembly. Overflow replaces every digit with a dash; otherwise the
   // encoded digits go out as-is, or with leading zeros blanked when enabled.
   // Digit 0 is never blanked so zero still reads as '0'.
   always_comb begin
`ifdef DISP_BCD_LZ_BLANK_EN
      logic seenNz;
      seenNz = 1'b0;
`endif
      frame = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         if (ovf_q) begin
            frame[i*8 +: 8] = {~point_q[i], SEG_DASH};
         end else begin
            frame[i*8 +: 8] = digitSeg[i*8 +: 8];
`ifdef DISP_BCD_LZ_BLANK_EN
            if (bcd_q[i*4 +: 4] != 4'd0) begin
               seenNz = 1'b1;
            end else if (!seenNz && (i != 0)) begin
               frame[i*8 +: 8] = {~point_q[i], SEG_BLANK[6:0]};
            end
`endif
         end
      end
   end

   // Load is honoured whenever busy is low, which includes the latch cycle,
   // so back-to-back frames need no idle gap.
   assign accept = load && ((state_q == IDLE) || (state_q == LATCH));

   // Next-state and bus outputs. Outputs are decoded from registered state so
   // an asynchronous reset drives the bus to its idle levels immediately.
   always_comb begin
      state_d   = state_q;
      convCnt_d = convCnt_q;
      bitIdx_d  = bitIdx_q;
      divCnt_d  = divCnt_q;
      bcd_d     = bcd_q;
      binSh_d   = binSh_q;
      point_d   = point_q;
      ovf_d     = ovf_q;
      busy      = 1'b0;
      done      = 1'b0;
      seg_clk   = 1'b0;
      seg_do    = 1'b0;
      seg_pen   = 1'b1;

      case (state_q)
         IDLE: begin
         end
         CONV: begin
            busy    = 1'b1;
            bcd_d   = {bcdAdj[BW-2:0], binSh_q[BIN_BITS-1]};
            binSh_d = {binSh_q[BIN_BITS-2:0], 1'b0};
            if (bcdAdj[BW-1]) begin
               ovf_d = 1'b1;
            end
            convCnt_d = convCnt_q + 1'b1;
            if (convCnt_q == CONV_LAST) begin
               state_d  = SHIFT;
               bitIdx_d = BIT_LAST;
               divCnt_d = '0;
            end
         end
         SHIFT: begin
            busy     = 1'b1;
            seg_pen  = 1'b0;
            seg_clk  = (divCnt_q >= DIV_HALF);
            seg_do   = frame[bitIdx_q];
            divCnt_d = divCnt_q + 1'b1;
            if (divCnt_q == DIV_LAST) begin
               divCnt_d = '0;
               if (bitIdx_q == '0) begin
                  state_d = LATCH;
               end else begin
                  bitIdx_d = bitIdx_q - 1'b1;
               end
            end
         end
         LATCH: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (accept) begin
         state_d   = CONV;
         convCnt_d = '0;
         bcd_d     = '0;
         binSh_d   = bin;
         point_d   = point;
         ovf_d     = 1'b0;
      end
   end

   assign ovf     = ovf_q;
   assign seg_clr = clr_q;

   // State and datapath registers. The clear line is held low only while in
   // reset and releases on the first clock after reset goes away.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         convCnt_q <= '0;
         bitIdx_q  <= '0;
         divCnt_q  <= '0;
         bcd_q     <= '0;
         binSh_q   <= '0;
         point_q   <= '0;
         ovf_q     <= 1'b0;
         clr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         convCnt_q <= convCnt_d;
         bitIdx_q  <= bitIdx_d;
         divCnt_q  <= divCnt_d;
         bcd_q     <= bcd_d;
         binSh_q   <= binSh_d;
         point_q   <= point_d;
         ovf_q     <= ovf_d;
         clr_q     <= 1'b1;
      end
   end

endmodule

// File: doc/disp_bcd_seq.md
Name: disp_bcd_seq

Overview:
- Parametrised sequential successor to the combinational hex-to-BCD display path.
- Latches a binary value on a load handshake and converts it to BCD by iterative shift-add-3 (double dabble), one bit per clock.
- Encodes each digit to 7-segment form, then serially shifts the frame out on the 4-wire segment-LED bus (clk/data/pen/clr).
- Sits between game logic (score/coin/time counters) and the on-board shift-register display.

Parameters:
- BIN_BITS, 32, width of binary input; legal range 4..32.
- DIGITS, 8, number of displayed decimal digits; legal range 1..8; BCD register is DIGITS*4 bits.
- CLK_DIV, 4, clk cycles per half-period of seg_clk; must be ≥1.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- load, input, 1, start request; accepted only when busy=0.
- bin, input, BIN_BITS, unsigned binary value; sampled on accepted load.
- point, input, DIGITS, decimal-point enable per digit; sampled on accepted load.
- busy, output, 1, high from the cycle after an accepted load until done.
- done, output, 1, one-cycle pulse when the frame has been latched into the display.
- ovf, output, 1, value exceeded 10^DIGITS-1; valid with done; held until the next accepted load.
- seg_clk, output, 1, serial shift clock (sout[3] equivalent).
- seg_do, output, 1, serial data, MSB first (sout[2]).
- seg_pen, output, 1, output-latch enable; low while shifting (sout[1]).
- seg_clr, output, 1, shift-register clear, active low (sout[0]).

Behaviour:
- Reset values (asynchronous, while rst_n=0): busy=0, done=0, ovf=0, seg_clk=0, seg_do=0, seg_pen=1, seg_clr=0.
- seg_clr goes 1 on the first clk edge after reset release and stays 1.
- Reset mid-operation aborts the frame and returns to IDLE; no done pulse is produced.
- State machine: IDLE -> CONV -> SHIFT -> LATCH -> IDLE.
- IDLE:
  - load=1 captures bin and point, clears the BCD register and ovf, sets busy, and enters CONV.
  - load while busy is ignored and is not queued.
- CONV: exactly BIN_BITS cycles.
  - Each cycle adds 3 to every BCD nibble ≥5, then shifts {bcd, bin} left by 1.
  - Any 1 shifted out of bcd[DIGITS*4-1] sets ovf.
  - Conversion latency is BIN_BITS cycles.
- Segment byte per digit: bit7=dp, bit6..0=g..a, active low (0 = lit).
  - Digits 0-9 use the standard glyphs; nibbles ≥10 never occur.
  - If ovf=1 at the end of CONV, every digit shows '-' (only g lit: 8'hBF, or 8'h3F with its point bit set).
- SHIFT: DIGITS*8 bits, most-significant digit first, bit7 first.
  - Per bit: seg_do updates and seg_clk=0 for CLK_DIV cycles, then seg_clk=1 for CLK_DIV cycles.
  - The receiver samples on the seg_clk rising edge.
  - seg_pen=0 throughout SHIFT.
- LATCH: one cycle after the last high phase.
  - seg_clk=0, seg_pen=1, done=1; busy falls in the same cycle and the next state is IDLE.
- Total latency from accepted load to done: BIN_BITS + DIGITS*8*2*CLK_DIV + 1 cycles (545 at defaults).
- bin=0 displays all zeros, or blanks with the optional feature; the least-significant digit always shows '0'.

Optional Feature:
- Macro: DISP_BCD_LZ_BLANK_EN.
- Defined: leading-zero digits above the most-significant non-zero digit are sent as 8'hFF (blank), except the least-significant digit; point bits still apply to blanked digits.
- Undefined: all DIGITS digits are shown, including leading zeros.
- Has no effect when ovf=1.

Decomposition:
- Package disp_bcd_pkg:
  - State encodings IDLE/CONV/SHIFT/LATCH.
  - Segment constants SEG_BLANK=8'hFF, SEG_DASH=7'h3F, and the 0-9 glyph table.
- One sub-module, bcd_to_seg7: combinational 4-bit nibble plus dp in, 8-bit active-low byte out.
- The FSM, double-dabble datapath and shifter stay in disp_bcd_seq.

Test Plan:
- Defaults, load bin=32'd12345678, point=0 -> 64 bits received in order F9,A4,B0,99,92,82,F8,80; ovf=0; done at cycle 545.
- bin=32'd99999999 -> eight 8'h90 bytes; ovf=0. bin=32'd100000000 -> eight 8'hBF bytes; ovf=1, held until the next load.
- With DISP_BCD_LZ_BLANK_EN, bin=42, point=8'h01 -> six 8'hFF, then 99, then 24 (final digit '2' with dp lit = 8'h24, since 8'hA4 with bit7 cleared); without the macro, the leading bytes are C0.
- load pulsed at cycle 10 and cycle 300 of a busy frame -> both ignored; exactly one done; the frame matches the first value.
- rst_n asserted during SHIFT -> outputs take reset values immediately; no done; a following load produces a correct full frame.
- BIN_BITS=8, DIGITS=3, CLK_DIV=1, bin=8'd255 -> bytes 0xA4, 0x92, 0x92 ('2','5','5'); latency 8+48+1=57 cycles.
